// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and constants for the memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_ACCESS = 2'b01,
    ARB_DONE   = 2'b10
  } arb_state_e;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } gnt_e;

  localparam logic        ChipEnable  = 1'b1;
  localparam logic        ChipDisable = 1'b0;
  localparam logic        WriteEnable = 1'b1;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// Access latency counter: loads MEM_LAT, counts down, flags the final cycle.
module mem_port_arbiter_lat_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic last
);

  localparam int CW = $clog2(MEM_LAT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Load takes precedence; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(MEM_LAT);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign last = (cnt_q == CW'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// MEM has fixed priority; a completed port is masked for the edge after its
// rdy pulse so a still-held request is not issued twice.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_rdy,
  output logic [DATA_W-1:0] if_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [3:0]        mem_sel,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rdy,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_sel,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              stallreq_if,
  output logic              stallreq_mem
);

  arb_state_e        state_q, state_d;
  gnt_e              gnt_q, gnt_d;
  logic              flush_q, flush_d;
  logic              ram_ce_q, ram_ce_d, ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [3:0]        ram_sel_q, ram_sel_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              if_rdy_q, if_rdy_d, mem_rdy_q, mem_rdy_d;
  logic [DATA_W-1:0] if_data_q, if_data_d, mem_rdata_q, mem_rdata_d;
  logic              cnt_load, cnt_dec, cnt_last;
  logic              mem_ok, if_ok;

  mem_port_arbiter_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .dec  (cnt_dec),
    .last (cnt_last)
  );

  // Arbitration, access sequencing and completion capture.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    flush_d     = flush_q;
    ram_ce_d    = ram_ce_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_sel_d   = ram_sel_q;
    ram_wdata_d = ram_wdata_q;
    if_rdy_d    = 1'b0;
    mem_rdy_d   = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    // The port that just completed sits out the DONE edge.
    mem_ok = mem_req && !((state_q == ARB_DONE) && (gnt_q == GNT_MEM));
    if_ok  = if_req && !if_flush && !((state_q == ARB_DONE) && (gnt_q == GNT_IF));
    case (state_q)
      ARB_IDLE, ARB_DONE: begin
        state_d  = ARB_IDLE;
        ram_ce_d = ChipDisable;
        ram_we_d = ~WriteEnable;
        if (mem_ok) begin
          state_d     = ARB_ACCESS;
          gnt_d       = GNT_MEM;
          flush_d     = 1'b0;
          ram_ce_d    = ChipEnable;
          ram_we_d    = mem_we;
          ram_addr_d  = mem_addr;
          ram_sel_d   = mem_sel;
          ram_wdata_d = mem_wdata;
          cnt_load    = 1'b1;
        end else if (if_ok) begin
          state_d     = ARB_ACCESS;
          gnt_d       = GNT_IF;
          flush_d     = 1'b0;
          ram_ce_d    = ChipEnable;
          ram_we_d    = ~WriteEnable;
          ram_addr_d  = if_addr;
          ram_sel_d   = 4'hF;
          ram_wdata_d = DATA_W'(ZeroWord);
          cnt_load    = 1'b1;
        end
      end
      ARB_ACCESS: begin
        // Write strobe lasts only the first access cycle.
        ram_we_d = ~WriteEnable;
        cnt_dec  = 1'b1;
        if ((gnt_q == GNT_IF) && if_flush) flush_d = 1'b1;
        if (cnt_last) begin
          state_d  = ARB_DONE;
          ram_ce_d = ChipDisable;
          if (gnt_q == GNT_MEM) begin
            mem_rdata_d = ram_rdata;
            mem_rdy_d   = 1'b1;
          end else if (!(flush_q || if_flush)) begin
            if_data_d = ram_rdata;
            if_rdy_d  = 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= GNT_IF;
      flush_q     <= 1'b0;
      ram_ce_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_sel_q   <= '0;
      ram_wdata_q <= '0;
      if_rdy_q    <= 1'b0;
      mem_rdy_q   <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      flush_q     <= flush_d;
      ram_ce_q    <= ram_ce_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_sel_q   <= ram_sel_d;
      ram_wdata_q <= ram_wdata_d;
      if_rdy_q    <= if_rdy_d;
      mem_rdy_q   <= mem_rdy_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign ram_ce       = ram_ce_q;
  assign ram_we       = ram_we_q;
  assign ram_addr     = ram_addr_q;
  assign ram_sel      = ram_sel_q;
  assign ram_wdata    = ram_wdata_q;
  assign if_rdy       = if_rdy_q;
  assign if_data      = if_data_q;
  assign mem_rdy      = mem_rdy_q;
  assign mem_rdata    = mem_rdata_q;
  assign stallreq_if  = if_req & ~if_rdy_q;
  assign stallreq_mem = mem_req & ~mem_rdy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_rdy;
  logic [31:0] if_addr, if_data;
  logic        mem_req, mem_we, mem_rdy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_sel, ram_sel;
  logic        ram_ce, ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        stallreq_if, stallreq_mem;

  int n_checks = 0;
  int n_errors = 0;
  int ce_rises = 0;
  int rises_before;
  logic ce_prev = 1'b0;

  always #5 clk = ~clk;

  // ROM model: word i reads as 0xC0DE0000 | i, zero word while disabled.
  assign ram_rdata = ram_ce ? (32'hC0DE_0000 | {2'b00, ram_addr[31:2]}) : 32'h0;

  always @(posedge clk) begin
    ce_prev <= ram_ce;
    if (ram_ce && !ce_prev) ce_rises <= ce_rises + 1;
  end

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdy(if_rdy), .if_data(if_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_sel(mem_sel), .mem_wdata(mem_wdata),
    .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_sel(ram_sel), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; if_req = 0; if_addr = 0; if_flush = 0;
    mem_req = 0; mem_we = 0; mem_addr = 0; mem_sel = 0; mem_wdata = 0;
    tick(); tick();
    chk("rst_ce", {31'd0, ram_ce}, 0);
    chk("rst_we", {31'd0, ram_we}, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_if_rdy", {31'd0, if_rdy}, 0);
    chk("rst_mem_rdy", {31'd0, mem_rdy}, 0);
    chk("rst_if_data", if_data, 0);
    rst = 1'b0;
    tick();

    // Fetch only
    if_req = 1; if_addr = 32'h8;
    #1 chk("f_stall", {31'd0, stallreq_if}, 1);
    tick();
    chk("f_ce1", {31'd0, ram_ce}, 1);
    chk("f_addr", ram_addr, 32'h8);
    chk("f_we", {31'd0, ram_we}, 0);
    chk("f_sel", {28'd0, ram_sel}, 32'hF);
    tick();
    chk("f_ce2", {31'd0, ram_ce}, 1);
    chk("f_rdy_early", {31'd0, if_rdy}, 0);
    tick();
    chk("f_rdy", {31'd0, if_rdy}, 1);
    chk("f_data", if_data, 32'hC0DE_0002);
    chk("f_ce_off", {31'd0, ram_ce}, 0);
    chk("f_stall_off", {31'd0, stallreq_if}, 0);
    tick();
    chk("f_no_reissue_ce", {31'd0, ram_ce}, 0);
    chk("f_rdy_pulse", {31'd0, if_rdy}, 0);
    if_req = 0;
    tick();
    chk("f_idle_ce", {31'd0, ram_ce}, 0);

    // Simultaneous: MEM first, then IF granted at the DONE edge
    if_req = 1; if_addr = 32'hC; mem_req = 1; mem_we = 0; mem_addr = 32'h100;
    tick();
    chk("s_addr_mem", ram_addr, 32'h100);
    chk("s_stall_if1", {31'd0, stallreq_if}, 1);
    tick();
    chk("s_stall_mem", {31'd0, stallreq_mem}, 1);
    tick();
    chk("s_mem_rdy", {31'd0, mem_rdy}, 1);
    chk("s_mem_rdata", mem_rdata, 32'hC0DE_0040);
    chk("s_stall_if2", {31'd0, stallreq_if}, 1);
    mem_req = 0;
    tick();
    chk("s_mem_rdy_off", {31'd0, mem_rdy}, 0);
    chk("s_if_ce", {31'd0, ram_ce}, 1);
    chk("s_if_addr", ram_addr, 32'hC);
    chk("s_stall_if3", {31'd0, stallreq_if}, 1);
    tick();
    chk("s_if_rdy_early", {31'd0, if_rdy}, 0);
    tick();
    chk("s_if_rdy", {31'd0, if_rdy}, 1);
    chk("s_if_data", if_data, 32'hC0DE_0003);
    if_req = 0;
    tick();

    // Store
    mem_req = 1; mem_we = 1; mem_sel = 4'b0011; mem_wdata = 32'hDEAD_BEEF; mem_addr = 32'h40;
    tick();
    chk("st_we1", {31'd0, ram_we}, 1);
    chk("st_ce", {31'd0, ram_ce}, 1);
    chk("st_addr", ram_addr, 32'h40);
    chk("st_sel", {28'd0, ram_sel}, 32'h3);
    chk("st_wdata", ram_wdata, 32'hDEAD_BEEF);
    tick();
    chk("st_we2", {31'd0, ram_we}, 0);
    chk("st_rdy_early", {31'd0, mem_rdy}, 0);
    tick();
    chk("st_rdy", {31'd0, mem_rdy}, 1);
    chk("st_we3", {31'd0, ram_we}, 0);
    mem_req = 0; mem_we = 0;
    tick();
    chk("st_rdy_pulse", {31'd0, mem_rdy}, 0);

    // Flush during the second ACCESS cycle of a fetch
    if_req = 1; if_addr = 32'h10;
    tick();
    chk("fl_ce1", {31'd0, ram_ce}, 1);
    tick();
    if_flush = 1;
    chk("fl_ce2", {31'd0, ram_ce}, 1);
    tick();
    chk("fl_ce_off", {31'd0, ram_ce}, 0);
    chk("fl_no_rdy", {31'd0, if_rdy}, 0);
    chk("fl_data_kept", if_data, 32'hC0DE_0003);
    if_flush = 0; if_req = 0;
    tick();
    chk("fl_no_rdy2", {31'd0, if_rdy}, 0);

    // Reset in the middle of a store access
    mem_req = 1; mem_we = 1; mem_sel = 4'hF; mem_wdata = 32'h1234_5678; mem_addr = 32'h44;
    tick();
    chk("r_we_before", {31'd0, ram_we}, 1);
    #2 rst = 1;
    #1;
    chk("r_ce", {31'd0, ram_ce}, 0);
    chk("r_we", {31'd0, ram_we}, 0);
    chk("r_if_rdy", {31'd0, if_rdy}, 0);
    chk("r_mem_rdy", {31'd0, mem_rdy}, 0);
    mem_req = 0; mem_we = 0;
    tick();
    rst = 0;
    tick();
    chk("r_idle_ce", {31'd0, ram_ce}, 0);
    chk("r_idle_rdy", {31'd0, mem_rdy}, 0);
    if_req = 1; if_addr = 32'h14;
    tick();
    chk("r_f_addr", ram_addr, 32'h14);
    tick(); tick();
    chk("r_f_rdy", {31'd0, if_rdy}, 1);
    chk("r_f_data", if_data, 32'hC0DE_0005);
    if_req = 0;
    tick();

    // Back-to-back fetches with a held request
    rises_before = ce_rises;
    if_req = 1; if_addr = 32'h20;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("b_ce", {31'd0, ram_ce}, 1);
      chk("b_addr", ram_addr, 32'h20 + 32'(4 * i));
      tick();
      chk("b_ce2", {31'd0, ram_ce}, 1);
      tick();
      chk("b_rdy", {31'd0, if_rdy}, 1);
      chk("b_data", if_data, 32'hC0DE_0008 + 32'(i));
      chk("b_ce_done", {31'd0, ram_ce}, 0);
      if (i == 2) if_req = 0;
      else        if_addr = 32'h24 + 32'(4 * i);
      tick();
      chk("b_no_dup", {31'd0, ram_ce}, 0);
      chk("b_rdy_off", {31'd0, if_rdy}, 0);
      tick();
    end
    tick();
    chk("b_ce_count", 32'(ce_rises - rises_before), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
